// File: rtl/layer_serializer_if.sv
// Bundle of the parallel-capture and serial-stream signals of layer_serializer.
// master drives the parallel vector and observes the stream; slave is the serializer.
interface layer_serializer_if #(
  parameter int unsigned neurons   = 10,
  parameter int unsigned dataWidth = 16
);
  logic                           in_valid;
  logic [neurons*dataWidth-1:0]   in_data;
  logic                           out_valid;
  logic [dataWidth-1:0]           out_data;
  logic                           out_last;
  logic                           busy;
  logic                           overflow;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output out_last,
    output busy,
    output overflow
  );
endinterface

// File: rtl/layer_serializer.sv
// Parallel-to-serial adapter: captures a vector of neuron words and streams them one per
// clock, with a one-deep pending buffer so the next vector can follow without a gap.
module layer_serializer #(
  parameter int unsigned neurons   = 10,
  parameter int unsigned dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  layer_serializer_if.slave    bus
);
  localparam int unsigned VecW = neurons * dataWidth;
  localparam int unsigned IdxW = $clog2(neurons);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(neurons - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   active_q, active_d;
  logic [VecW-1:0]   pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              overflow_q, overflow_d;

  logic                 out_valid;
  logic [dataWidth-1:0] out_data;
  logic                 out_last;
  logic                 busy;

  // State register; datapath registers share the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      idx_q           <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      idx_q           <= idx_d;
      overflow_q      <= overflow_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    idx_d           = idx_q;
    overflow_d      = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          active_d = bus.in_data;
          idx_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (idx_q != LastIdx) begin
          idx_d = idx_q + IdxW'(1);
          if (bus.in_valid) begin
            if (!pending_valid_q) begin
              pending_d       = bus.in_data;
              pending_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else begin
          idx_d = '0;
          if (pending_valid_q) begin
            // Pending slot drains into active this cycle, so a new strobe refills it.
            active_d = pending_q;
            if (bus.in_valid) begin
              pending_d = bus.in_data;
            end else begin
              pending_valid_d = 1'b0;
            end
          end else if (bus.in_valid) begin
            active_d = bus.in_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on registered state.
  always_comb begin
    out_valid = (state_q == StShift);
    out_data  = '0;
    if (out_valid) begin
      out_data = active_q[int'(idx_q)*dataWidth +: dataWidth];
    end
    out_last = out_valid && (idx_q == LastIdx);
    busy     = out_valid || pending_valid_q;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.busy      = busy;
  assign bus.overflow  = overflow_q;
endmodule
